// File: rtl/bcd2binary.sv
// Four-digit BCD to unsigned binary converter using reverse double-dabble.
// One shift/correct iteration per clock, tran_en/tran_done handshake.
module bcd2binary #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tran_en,
    input  logic [3:0]       thou_data,
    input  logic [3:0]       hund_data,
    input  logic [3:0]       tens_data,
    input  logic [3:0]       unit_data,
    output logic [BIN_W-1:0] data_out,
    output logic             tran_done,
    output logic             busy,
    output logic             bcd_err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_q, bcd_nxt;
    logic [BIN_W-1:0]   bin_q, bin_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               err_q, err_nxt;
    logic [BIN_W-1:0]   data_out_nxt;
    logic               done_nxt, busy_nxt, bcd_err_nxt;
    logic [BCD_W+BIN_W-1:0] shifted;

    // A digit of 8 or more after a right shift carried a "ten" down; removing 3
    // turns the borrowed 16/2 weighting back into 10/2.
    function automatic logic [3:0] dabble_fix(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    function automatic logic digit_bad(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    always_comb begin
        state_nxt    = state;
        bcd_nxt      = bcd_q;
        bin_nxt      = bin_q;
        cnt_nxt      = cnt_q;
        err_nxt      = err_q;
        data_out_nxt = data_out;
        done_nxt     = 1'b0;
        busy_nxt     = busy;
        bcd_err_nxt  = bcd_err;
        shifted      = {bcd_q, bin_q} >> 1;

        case (state)
            IDLE: begin
                if (tran_en) begin
                    bcd_nxt   = {thou_data, hund_data, tens_data, unit_data};
                    bin_nxt   = '0;
                    cnt_nxt   = '0;
                    err_nxt   = digit_bad(thou_data) | digit_bad(hund_data) |
                                digit_bad(tens_data) | digit_bad(unit_data);
                    busy_nxt  = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    bcd_nxt[4*i +: 4] = dabble_fix(shifted[BIN_W + 4*i +: 4]);
                end
                bin_nxt = shifted[BIN_W-1:0];
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    data_out_nxt = err_q ? '0 : shifted[BIN_W-1:0];
                    bcd_err_nxt  = err_q;
                    done_nxt     = 1'b1;
                    busy_nxt     = 1'b0;
                    cnt_nxt      = '0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            data_out  <= '0;
            tran_done <= 1'b0;
            busy      <= 1'b0;
            bcd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bcd_q     <= bcd_nxt;
            bin_q     <= bin_nxt;
            cnt_q     <= cnt_nxt;
            err_q     <= err_nxt;
            data_out  <= data_out_nxt;
            tran_done <= done_nxt;
            busy      <= busy_nxt;
            bcd_err   <= bcd_err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd2binary.sv
// Self-checking bench for bcd2binary: directed handshake cases plus random
// digit sets compared against a decimal-arithmetic reference.
module tb_bcd2binary;

    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tran_en = 1'b0;
    logic [3:0]       thou_data = '0, hund_data = '0, tens_data = '0, unit_data = '0;
    logic [BIN_W-1:0] data_out;
    logic             tran_done, busy, bcd_err;

    int n_checks = 0;
    int n_pass   = 0;

    bcd2binary #(.DIGITS(4), .BIN_W(BIN_W)) dut (
        .clk(clk), .rst_n(rst_n), .tran_en(tran_en),
        .thou_data(thou_data), .hund_data(hund_data),
        .tens_data(tens_data), .unit_data(unit_data),
        .data_out(data_out), .tran_done(tran_done),
        .busy(busy), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int ref_bad(input int t, input int h, input int te, input int u);
        return (t > 9 || h > 9 || te > 9 || u > 9) ? 1 : 0;
    endfunction

    function automatic int ref_bin(input int t, input int h, input int te, input int u);
        if (ref_bad(t, h, te, u) != 0) return 0;
        return t * 1000 + h * 100 + te * 10 + u;
    endfunction

    task automatic set_digits(input int t, input int h, input int te, input int u);
        thou_data = 4'(t); hund_data = 4'(h); tens_data = 4'(te); unit_data = 4'(u);
    endtask

    // Waits (bounded) for tran_done; returns negedges elapsed.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!tran_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_req(input string tag, input int t, input int h, input int te, input int u);
        int lat;
        @(negedge clk);
        set_digits(t, h, te, u);
        tran_en = 1'b1;
        @(negedge clk);
        tran_en = 1'b0;
        set_digits($urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15));
        check({tag, "_busy"}, int'(busy), 1);
        wait_done(lat);
        check({tag, "_lat"}, lat, 14);
        check({tag, "_data"}, int'(data_out), ref_bin(t, h, te, u));
        check({tag, "_err"}, int'(bcd_err), ref_bad(t, h, te, u));
        check({tag, "_busy_done"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(tran_done), 0);
    endtask

    initial begin
        int lat, ndone, first_data, t, h, te, u;

        #12;
        check("rst_data", int'(data_out), 0);
        check("rst_done", int'(tran_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(bcd_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req("d1234", 1, 2, 3, 4);
        run_req("d9999", 9, 9, 9, 9);
        run_req("d0000", 0, 0, 0, 0);
        run_req("d0106", 0, 1, 0, 6);
        run_req("dA001", 10, 0, 0, 1);
        run_req("d0042", 0, 0, 4, 2);

        // tran_en held high; digits change during the first conversion
        @(negedge clk);
        set_digits(1, 2, 3, 4);
        tran_en = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        set_digits(5, 6, 7, 8);
        lat = 0;
        while (!tran_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("hold_first", int'(data_out), 1234);
        @(negedge clk);
        wait_done(lat);
        check("hold_spacing", lat + 1, 15);
        check("hold_second", int'(data_out), 5678);
        tran_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hold_stop", int'(busy), 0);

        // asynchronous reset mid-conversion
        @(negedge clk);
        set_digits(3, 3, 3, 3);
        tran_en = 1'b1;
        @(negedge clk);
        tran_en = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_data", int'(data_out), 0);
        check("abort_err", int'(bcd_err), 0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (tran_done) ndone++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (tran_done) ndone++;
        end
        check("abort_nodone", ndone, 0);
        run_req("d0055", 0, 0, 5, 5);

        // extra tran_en pulse while busy must be ignored
        @(negedge clk);
        set_digits(0, 7, 7, 7);
        tran_en = 1'b1;
        @(negedge clk);
        tran_en = 1'b0;
        repeat (3) @(negedge clk);
        set_digits(8, 8, 8, 8);
        tran_en = 1'b1;
        @(negedge clk);
        tran_en = 1'b0;
        ndone = 0;
        first_data = -1;
        repeat (40) begin
            @(negedge clk);
            if (tran_done) begin
                ndone++;
                if (first_data < 0) first_data = int'(data_out);
            end
        end
        check("ignore_count", ndone, 1);
        check("ignore_data", first_data, 777);
        check("ignore_idle", int'(busy), 0);

        // random requests, occasional invalid digits
        for (int k = 0; k < 20; k++) begin
            t  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            h  = $urandom_range(0, 9);
            te = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            u  = $urandom_range(0, 9);
            run_req($sformatf("rnd%0d", k), t, h, te, u);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/bcd2binary.md
Name: bcd2binary

Overview:
- Sequential converter from four BCD digits (thousands, hundreds, tens, units) to an unsigned binary value.
- Inverse of the Binary2BCD block. Uses the same tran_en/tran_done handshake and the same digit port naming, so the two blocks can be chained back-to-back (e.g. a keypad or display-edit path returning to binary arithmetic).
- Algorithm: reverse double-dabble, one iteration per clock.

Parameters:
- DIGITS, 4: number of BCD digits. Fixed at 4 in this revision; a change requires a port-list change.
- BIN_W, 14: output width and iteration count. Must satisfy 10^DIGITS-1 < 2^BIN_W (9999 < 16384).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- tran_en  input  1  conversion request, level-sampled in IDLE
- thou_data  input  4  BCD thousands digit
- hund_data  input  4  BCD hundreds digit
- tens_data  input  4  BCD tens digit
- unit_data  input  4  BCD units digit
- data_out  output  BIN_W  converted binary value, registered, held until next completion
- tran_done  output  1  one-cycle pulse, result valid
- busy  output  1  high while a conversion is in progress
- bcd_err  output  1  registered with tran_done: the last captured input had a digit >9

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; data_out=0, tran_done=0, busy=0, bcd_err=0; shift register and iteration counter cleared. Reset mid-conversion aborts it; no tran_done is produced for the aborted request.
- States: IDLE and CONV.
- IDLE, rising edge E0 with tran_en=1:
  - Capture {thou,hund,tens,unit} into a 16-bit BCD register; clear a BIN_W-bit binary register; clear the counter.
  - Compute a digit-valid flag: any digit >9 sets an internal err.
  - Set busy=1; go to CONV.
- IDLE with tran_en=0: hold all outputs; tran_done=0.
- CONV, each edge (iteration):
  - Shift the concatenation {bcd, bin} right by 1; the BCD LSB enters the binary MSB.
  - Then, for each 4-bit BCD digit of the shifted value: if the digit is >=8, subtract 3 (digits are corrected independently within one cycle).
  - Counter increments.
- Completion edge (the BIN_W-th CONV edge, E_BIN_W = E14):
  - data_out <= next binary value, or 0 if err.
  - bcd_err <= err; tran_done <= 1; busy <= 0; state <= IDLE.
- Latency: tran_done is high in the cycle following E14, i.e. 14 clocks after the capture edge. tran_done deasserts on the next edge.
- Inputs are sampled only at the capture edge. Digit changes during CONV do not affect the result.
- tran_en is ignored while busy=1; no queueing.
- tran_en held high continuously: a new capture occurs at the edge right after the completion edge (IDLE, E15). Throughput is one result per 15 clocks; tran_done pulses every 15 cycles.
- bcd_err and data_out hold their values until the next completion. bcd_err is cleared by the next valid completion.
- Arithmetic: all unsigned. The subtract-3 correction never underflows because it is applied only to digits >=8.

Test Plan:
- Reset release, then tran_en=1 with digits 1,2,3,4 -> exactly 14 clocks after the capture edge: tran_done=1 for one cycle, data_out=1234 (14'h04D2), bcd_err=0, busy low in that cycle.
- Digits 9,9,9,9 -> data_out=9999 (14'h270F). Digits 0,0,0,0 -> data_out=0 with tran_done pulse. Digits 0,1,0,6 -> data_out=106 (7'b1101010), matching a round-trip through Binary2BCD.
- Digits A,0,0,1 -> tran_done=1, bcd_err=1, data_out=0. A following valid request with 0,0,4,2 -> data_out=42, bcd_err=0.
- tran_en held high, inputs changed mid-conversion (1234 -> 5678 at iteration 5) -> first result 1234; next capture at the edge after done yields 5678; tran_done pulses spaced exactly 15 clocks.
- rst_n pulsed low at iteration 7 -> all outputs 0 immediately (asynchronous), no tran_done. After release, a new request for 0,0,5,5 -> data_out=55 after 14 clocks.
- tran_en pulsed during busy (extra pulse at iteration 3) -> ignored: a single tran_done, no extra conversion started.
